// File: rtl/fifo_rd_unpack_60to20.sv
// rtl/fifo_rd_unpack_60to20.sv - pops 60-bit FIFO words, streams them as three 20-bit beats (out_last when FIFO_RD_LAST_EN)
module fifo_rd_unpack_60to20 #(
    parameter int DW = 60,
    parameter int BW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    output logic          fifo_re,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
`ifdef FIFO_RD_LAST_EN
    ,
    output logic          out_last
`endif
);

    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] next_q, next_d;
    logic [1:0]    occ_q, occ_d;
    logic [1:0]    beat_q, beat_d;
    logic          inflight_q, inflight_d;

    logic          xfer;
    logic          retire;
    logic [1:0]    occ_after;
    logic [2:0]    committed;

    // Pop only when the buffer can absorb every word already requested plus this one
    always_comb begin
        committed = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_re   = !rst && !clr && !fifo_empty && (committed < 3'd2);
    end

    // Present the selected 20-bit slice of the head word
    always_comb begin
        out_valid = (occ_q != 2'd0);
        case (beat_q)
            2'd0:    out_data = hold_q[BW-1:0];
            2'd1:    out_data = hold_q[2*BW-1:BW];
            default: out_data = hold_q[3*BW-1:2*BW];
        endcase
    end

`ifdef FIFO_RD_LAST_EN
    // Flag the third beat of the head word
    always_comb begin
        out_last = out_valid && (beat_q == 2'd2);
    end
`endif

    // Beat stepping, word retire, capture of returning read data and flush
    always_comb begin
        hold_d     = hold_q;
        next_d     = next_q;
        beat_d     = beat_q;
        inflight_d = fifo_re;
        xfer       = out_valid && out_ready;
        retire     = xfer && (beat_q == 2'd2);

        if (xfer) begin
            beat_d = retire ? 2'd0 : beat_q + 2'd1;
        end
        if (retire) begin
            hold_d = next_q;
        end

        // Tail slot is chosen after the retire so a word landing in an
        // emptied buffer goes straight to the head register.
        occ_after = occ_q - {1'b0, retire};
        if (inflight_q) begin
            if (occ_after == 2'd0) begin
                hold_d = fifo_dout;
            end else begin
                next_d = fifo_dout;
            end
        end
        occ_d = occ_after + {1'b0, inflight_q};

        // Flush drops buffered words, the partial word and any returning read
        if (clr) begin
            occ_d      = 2'd0;
            beat_d     = 2'd0;
            inflight_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            next_q     <= '0;
            occ_q      <= 2'd0;
            beat_q     <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            next_q     <= next_d;
            occ_q      <= occ_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpack_60to20.sv
// tb/tb_fifo_rd_unpack_60to20.sv - self-checking bench for fifo_rd_unpack_60to20 with a behavioural FIFO and beat scoreboard
module tb_fifo_rd_unpack_60to20;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [59:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_re;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef FIFO_RD_LAST_EN
    logic        out_last;
    logic        s_last;
`endif

    fifo_rd_unpack_60to20 #(.DW(60), .BW(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_re    (fifo_re),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef FIFO_RD_LAST_EN
        ,
        .out_last   (out_last)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural 512-deep FIFO with one-cycle registered read
    logic [59:0] mem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_re) begin
            fifo_dout <= mem[rd_ptr % 512];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic [19:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [59:0] word;
        logic [19:0] b0;
        logic [19:0] b1;
        logic [19:0] b2;
    } vec_t;

    beat_t exp_q[$];
    vec_t  tab [5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_beats = 0;
    int n_re = 0;
    int last_beat_cyc = 0;
    logic        stall_p = 1'b0;
    logic [19:0] stall_data = '0;
    logic        s_re;
    logic        s_valid;
    logic [19:0] s_data;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [59:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[59:0];
    endfunction

    // Word enters the FIFO; the reference stream gains its three slices
    task automatic push(input logic [59:0] w);
        beat_t b;
        mem[wr_ptr % 512] = w;
        wr_ptr = wr_ptr + 1;
        for (int k = 0; k < 3; k++) begin
            b.d = 20'((w >> (20 * k)) & 60'hFFFFF);
            b.l = (k == 2);
            exp_q.push_back(b);
        end
    endtask

    // Called at the falling edge: record outputs and score any transfer
    task automatic sample();
        beat_t e;
        s_re    = fifo_re;
        s_valid = out_valid;
        s_data  = out_data;
`ifdef FIFO_RD_LAST_EN
        s_last  = out_last;
`endif
        chk("re_while_empty", 64'(fifo_re & fifo_empty), 64'd0);
        if (stall_p) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'(stall_data));
        end
        if (!rst && !clr && out_valid && out_ready) begin
            chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 64'(out_data), 64'(e.d));
`ifdef FIFO_RD_LAST_EN
                chk("beat_last", 64'(out_last), 64'(e.l));
`endif
            end
            n_beats++;
            last_beat_cyc = cyc;
        end
        if (fifo_re) n_re++;
        stall_p    = out_valid && !out_ready && !clr && !rst;
        stall_data = out_data;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_b;
        int base_r;
        int first;
        logic [59:0] w0;

        tab[0] = '{60'hFEDCBA987654321, 20'h54321, 20'hA9876, 20'hFEDCB};
        tab[1] = '{60'h000000000000000, 20'h00000, 20'h00000, 20'h00000};
        tab[2] = '{60'hFFFFFFFFFFFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
        tab[3] = '{60'h123456789ABCDEF, 20'hBCDEF, 20'h6789A, 20'h12345};
        tab[4] = '{60'h00001FFFFF00000, 20'h00000, 20'hFFFFF, 20'h00001};

        // Reset hold with data waiting in the FIFO
        rst = 1'b1;
        clr = 1'b0;
        out_ready = 1'b0;
        push(60'h0AB_CDEF_0123_4567);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_re", 64'(s_re), 64'd0);
            chk("rst_valid", 64'(s_valid), 64'd0);
            chk("rst_data", 64'(s_data), 64'd0);
`ifdef FIFO_RD_LAST_EN
            chk("rst_last", 64'(s_last), 64'd0);
`endif
        end
        rst = 1'b0;
        tick();
        chk("first_re_after_rst", 64'(s_re), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("rst_word_drained", 64'(exp_q.size()), 64'd0);

        // Table of single words into an idle FIFO
        for (int v = 0; v < 5; v++) begin
            push(tab[v].word);
            tick();
            chk("tab_re", 64'(s_re), 64'd1);
            tick();
            chk("tab_lat_valid", 64'(s_valid), 64'd0);
            tick();
            chk("tab_b0_valid", 64'(s_valid), 64'd1);
            chk("tab_b0", 64'(s_data), 64'(tab[v].b0));
`ifdef FIFO_RD_LAST_EN
            chk("tab_b0_last", 64'(s_last), 64'd0);
`endif
            tick();
            chk("tab_b1", 64'(s_data), 64'(tab[v].b1));
`ifdef FIFO_RD_LAST_EN
            chk("tab_b1_last", 64'(s_last), 64'd0);
`endif
            tick();
            chk("tab_b2", 64'(s_data), 64'(tab[v].b2));
`ifdef FIFO_RD_LAST_EN
            chk("tab_b2_last", 64'(s_last), 64'd1);
`endif
            tick();
            chk("tab_idle_valid", 64'(s_valid), 64'd0);
            tick();
        end

        // Streaming: 10 preloaded words, 30 back-to-back beats
        base_b = n_beats;
        base_r = n_re;
        first = -1;
        for (int i = 0; i < 10; i++) push(rand_word());
        for (int i = 0; i < 60 && (n_beats - base_b) < 30; i++) begin
            tick();
            if (first < 0 && n_beats != base_b) first = last_beat_cyc;
        end
        chk("stream_beats", 64'(n_beats - base_b), 64'd30);
        chk("stream_span", 64'(last_beat_cyc - first), 64'd29);
        chk("stream_pops", 64'(n_re - base_r), 64'd10);
        for (int i = 0; i < 3; i++) tick();

        // Backpressure: stalled output pops at most two words
        out_ready = 1'b0;
        base_b = n_beats;
        base_r = n_re;
        w0 = rand_word();
        push(w0);
        for (int i = 0; i < 4; i++) push(rand_word());
        for (int i = 0; i < 20; i++) tick();
        chk("bp_pops", 64'(n_re - base_r), 64'd2);
        chk("bp_valid", 64'(s_valid), 64'd1);
        chk("bp_data", 64'(s_data), 64'(w0[19:0]));
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (n_beats - base_b) < 15; i++) tick();
        chk("bp_beats", 64'(n_beats - base_b), 64'd15);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) tick();

        // Flush mid-word with a read returning in the flush cycle
        push(rand_word());
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) push(rand_word());
        tick();
        chk("flush_pre_re", 64'(s_re), 64'd1);
        clr = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        tick();
        chk("flush_re_in_clr", 64'(s_re), 64'd0);
        clr = 1'b0;
        out_ready = 1'b1;
        base_b = n_beats;
        tick();
        chk("flush_valid", 64'(s_valid), 64'd0);
        chk("flush_re", 64'(s_re), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("flush_no_beats", 64'(n_beats - base_b), 64'd0);
        push(rand_word());
        for (int i = 0; i < 7; i++) tick();
        chk("flush_after_beats", 64'(n_beats - base_b), 64'd3);

        // Empty edge: one word every 4 cycles
        base_b = n_beats;
        base_r = n_re;
        for (int i = 0; i < 8; i++) begin
            push(rand_word());
            for (int k = 0; k < 4; k++) tick();
        end
        for (int i = 0; i < 4; i++) tick();
        chk("edge_beats", 64'(n_beats - base_b), 64'd24);
        chk("edge_pops", 64'(n_re - base_r), 64'd8);
        chk("edge_drained", 64'(exp_q.size()), 64'd0);

        // Random pushes, random ready, occasional flush
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 63) == 0) begin
                clr = 1'b1;
                exp_q.delete();
            end else begin
                clr = 1'b0;
                if ($urandom_range(0, 9) < 4) push(rand_word());
            end
            tick();
        end
        clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        chk("rand_idle_valid", 64'(s_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_unpack_60to20.md
# fifo_rd_unpack_60to20

Read-side consumer for the 512x60 FIFO. It pops 60-bit words through the FIFO's `re`/`empty` port, absorbing the one-cycle registered RAM read latency. Each word is re-emitted as three 20-bit beats, LSB slice first, on a valid/ready stream. A two-word internal buffer with read prefetch sustains one beat per cycle while the FIFO stays non-empty.

## Interface
Parameters:
- `DW`, 60: FIFO word width; must equal 3*`BW`.
- `BW`, 20: output beat width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `clr`  in  1  synchronous flush; wire it to the same net as the FIFO's `clr`.
- `fifo_dout`  in  DW  FIFO read data; valid the cycle after `fifo_re`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_re`  out  1  FIFO pop request, combinational.
- `out_data`  out  BW  current beat.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accept.
- `out_last`  out  1  third beat of a word. Present only with `FIFO_RD_LAST_EN`.

## Operation
- State:
  - `hold` (DW) and `next` (DW) word registers.
  - `occ`: words buffered, 0..2.
  - `inflight`: 1 bit, `fifo_re` was asserted last cycle.
  - `beat`: index 0..2 into `hold`.
- `fifo_re = !rst & !clr & !fifo_empty & (occ + inflight < 2)`. The block never pops an empty FIFO and never over-commits the buffer.
- Capture: when `inflight` is 1, `fifo_dout` is written to the buffer tail. The tail is `hold` if the effective occupancy after this cycle's pop is 0, otherwise `next`.
- Output:
  - `out_valid = (occ != 0)`.
  - `out_data = hold[BW*beat +: BW]`.
  - Beat 0 is bits 19:0, beat 1 is bits 39:20, beat 2 is bits 59:40.
- Handshake: a transfer occurs when `out_valid & out_ready`.
  - On a transfer with `beat < 2`: `beat` increments.
  - On a transfer with `beat == 2`: `beat` goes to 0, the word is retired, `next` moves into `hold`, and `occ` decrements.
- Simultaneous retire and capture in the same cycle:
  - `occ` is unchanged.
  - If `occ` was 1, the captured word goes directly to `hold`.
  - If `occ` was 2, `next` moves to `hold` and the captured word goes to `next`.
- Stream rules:
  - While `out_valid` is 1 and `out_ready` is 0, `out_data` (and `out_last`) stay stable.
  - `out_valid` does not drop until the beat transfers.
- `clr` (and `rst`):
  - Next cycle: `occ=0`, `beat=0`, `inflight=0`.
  - Any word arriving from a pop issued the cycle before `clr` is discarded.
  - `fifo_re` is 0 while `clr` is asserted.
  - `clr` takes effect mid-word; partially sent words are dropped.
- `rst` has priority over `clr`. `clr` has priority over all other updates.

## Timing
- Reset values:
  - Outputs: `fifo_re=0`, `out_valid=0`, `out_data=0`, `out_last=0`.
  - Internal: `occ=0`, `beat=0`, `inflight=0`, `hold=next=0`.
- Latency: FIFO non-empty at cycle t with the buffer empty gives `fifo_re=1` at t, capture at t+1, and `out_valid=1` at t+2.
- Throughput: 3 beats per 3 cycles sustained with `out_ready` held 1 and the FIFO non-empty; there are no bubbles between words.
- Backpressure: with `out_ready=0`, at most 2 words are popped, after which `fifo_re` stays 0.
- `fifo_re` depends combinationally on `fifo_empty`, `clr`, and state only. It does not depend on `out_ready`.

## Configuration
- `FIFO_RD_LAST_EN` defined:
  - The `out_last` port exists.
  - `out_last = out_valid & (beat == 2)`.
  - Reset value is 0.
- `FIFO_RD_LAST_EN` undefined:
  - The port is absent.
  - All other behaviour is identical.

## Test plan
- Reset hold: `rst=1` for 3 cycles with the FIFO holding data. Required: `fifo_re=0` and `out_valid=0` throughout; the first `fifo_re=1` occurs in the cycle after `rst` falls.
- Single word: push `0xFEDCBA987654321` to an empty FIFO with `out_ready=1`. Required:
  - Beats `0x54321`, `0xA9876`, `0xFEDCB` on 3 consecutive cycles.
  - `out_valid` first high 2 cycles after `empty` falls.
  - `out_last` only on the third beat.
- Streaming: preload 10 words and hold `out_ready=1`. Required: 30 beats on 30 consecutive cycles in order, and exactly 10 `fifo_re` pulses.
- Backpressure: preload 5 words, hold `out_ready=0` for 20 cycles, then release. Required:
  - Exactly 2 `fifo_re` pulses while stalled.
  - `out_data` stable at beat 0 of word 0.
  - After release, all 15 beats are delivered in order.
- Flush mid-word: 4 words queued; assert `clr` for 1 cycle after beat 1 of word 0. Required:
  - Next cycle `out_valid=0` and `fifo_re=0`.
  - An in-flight word is discarded.
  - A subsequent single push is output starting at beat 0.
- Empty edge: push one word every 4 cycles with `out_ready=1`. Required: `fifo_re` never asserts while `fifo_empty=1`, and no beat is duplicated or dropped across 8 words.
